// File: rtl/uart_tx_buffer.sv
// Transmit byte FIFO plus frame sequencer for uart_tx: holds each byte in
// o_tx_data for a whole frame and retires it on i_tx_done.
module uart_tx_buffer #(
    parameter int DEPTH  = 16,
    parameter int THRESH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_wr_en,
    input  logic [7:0]                 i_wr_data,
    input  logic                       i_flush,
    input  logic                       i_tx_enable,
    input  logic                       i_cts_n,
    input  logic                       i_tx_done,
    output logic                       o_start_tx,
    output logic [7:0]                 o_tx_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic                       o_overflow,
    output logic                       o_tx_low,
    output logic                       o_busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_LOW  = LW'(THRESH);

    typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;

    state_t          r_state, w_next;
    logic [7:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wptr, r_rptr;
    logic [LW-1:0]   r_level;
    logic            r_overflow;
    logic [7:0]      r_tx_data;
    logic            r_start_tx;

    logic            w_full, w_empty, w_pop, w_push;

    assign w_full  = (r_level == LVL_FULL);
    assign w_empty = (r_level == '0);
    // A pop in the same cycle frees a slot, so a push at full still lands.
    assign w_pop   = (r_state == LOAD) && !i_flush;
    assign w_push  = i_wr_en && !i_flush && (!w_full || w_pop);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (!w_empty && i_tx_enable && !i_cts_n && !i_flush) w_next = LOAD;
            LOAD: w_next = i_flush ? IDLE : SEND;
            SEND: if (i_tx_done) w_next = GAP;
            GAP:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_start_tx <= 1'b0;
            r_tx_data  <= 8'h00;
        end else begin
            r_state    <= w_next;
            r_start_tx <= (w_next == SEND);
            if (w_pop) r_tx_data <= r_mem[r_rptr];
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr] <= i_wr_data;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else if (i_flush) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
            if (i_wr_en && w_full && !w_pop) r_overflow <= 1'b1;
        end
    end

    assign o_start_tx = r_start_tx;
    assign o_tx_data  = r_tx_data;
    assign o_full     = w_full;
    assign o_empty    = w_empty;
    assign o_level    = r_level;
    assign o_overflow = r_overflow;
    assign o_tx_low   = (r_level <= LVL_LOW);
    assign o_busy     = (r_state != IDLE);
endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed bench for uart_tx_buffer: a per-cycle vector table for the first
// frame, then hand sequences for fill/overflow, wrap, flow control, flush, reset.
module tb_uart_tx_buffer;
    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en, flush, tx_enable, cts_n, tx_done;
    logic [7:0] wr_data;
    logic       start_tx, full, empty, overflow, tx_low, busy;
    logic [7:0] tx_data;
    logic [4:0] level;

    int total = 0;
    int bad   = 0;

    uart_tx_buffer #(.DEPTH(16), .THRESH(4)) dut (
        .i_clk(clk), .i_reset(reset), .i_wr_en(wr_en), .i_wr_data(wr_data),
        .i_flush(flush), .i_tx_enable(tx_enable), .i_cts_n(cts_n),
        .i_tx_done(tx_done), .o_start_tx(start_tx), .o_tx_data(tx_data),
        .o_full(full), .o_empty(empty), .o_level(level),
        .o_overflow(overflow), .o_tx_low(tx_low), .o_busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr_en;
        logic [7:0] wr_data;
        logic       tx_done;
        logic       start;
        logic [7:0] data;
        logic [4:0] lvl;
        logic       emp;
        logic       bsy;
    } vec_t;

    vec_t vecs [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        wr_en = 1'b1; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    // Wait for a frame request, check the byte, then complete it with tx_done.
    task automatic send_one(input logic [7:0] exp);
        int n = 0;
        while (!start_tx && n < 20) begin
            tick();
            n++;
        end
        check("start_tx timeout", int'(start_tx), 1);
        check("frame byte", int'(tx_data), int'(exp));
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("gap start_tx", int'(start_tx), 0);
        check("gap data held", int'(tx_data), int'(exp));
        tick();
        check("idle after gap", int'(busy), 0);
    endtask

    initial begin
        reset = 1'b1; wr_en = 0; wr_data = 0; flush = 0;
        tx_enable = 0; cts_n = 1; tx_done = 0;

        vecs[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 5'd1, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 5'd1, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 5'd0, 1'b1, 1'b1};
        vecs[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 5'd0, 1'b1, 1'b1};
        vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 5'd0, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 5'd0, 1'b1, 1'b0};

        repeat (3) tick();
        check("rst level", int'(level), 0);
        check("rst flags", int'({empty, full, tx_low, overflow, busy, start_tx}), 'b101000);
        check("rst data", int'(tx_data), 0);
        reset = 1'b0;
        tick();

        // First frame, cycle by cycle
        tx_enable = 1; cts_n = 0;
        for (int i = 0; i < 6; i++) begin
            wr_en = vecs[i].wr_en; wr_data = vecs[i].wr_data; tx_done = vecs[i].tx_done;
            tick();
            check($sformatf("vec%0d", i),
                  int'({start_tx, tx_data, level, empty, busy}),
                  int'({vecs[i].start, vecs[i].data, vecs[i].lvl, vecs[i].emp, vecs[i].bsy}));
        end
        wr_en = 0; tx_done = 0;

        // Fill to full, then overflow, then drain in order
        tx_enable = 0;
        for (int i = 0; i < 16; i++) push(8'(i));
        check("full at 16", int'(full), 1);
        check("no ovf at 16", int'(overflow), 0);
        push(8'h10);
        check("ovf at 17", int'(overflow), 1);
        check("level 16", int'(level), 16);
        tx_enable = 1;
        for (int i = 0; i < 16; i++) send_one(8'(i));
        check("drained empty", int'(empty), 1);
        check("ovf sticky", int'(overflow), 1);
        flush = 1; tick(); flush = 0;
        check("flush clears ovf", int'(overflow), 0);

        // Push during the LOAD edge while full, then flush mid-SEND
        tx_enable = 0;
        for (int i = 0; i < 16; i++) push(8'h20 + 8'(i));
        tx_enable = 1;
        tick();
        check("in LOAD", int'({busy, start_tx}), 'b10);
        push(8'h30);
        check("push+pop level", int'(level), 16);
        check("push+pop ovf", int'(overflow), 0);
        check("push+pop send", int'({start_tx, tx_data}), int'({1'b1, 8'h20}));
        flush = 1; tick(); flush = 0;
        check("flush level", int'(level), 0);
        check("flush ovf", int'(overflow), 0);
        send_one(8'h20);

        // Write pointer wrap and low watermark
        tx_enable = 0;
        for (int i = 0; i < 10; i++) push(8'h40 + 8'(i));
        tx_enable = 1;
        for (int i = 0; i < 10; i++) send_one(8'h40 + 8'(i));
        tx_enable = 0;
        for (int i = 0; i < 12; i++) begin
            push(8'h50 + 8'(i));
            check($sformatf("tx_low lvl%0d", i + 1), int'({level, tx_low}),
                  int'({5'(i + 1), (i + 1 <= 4) ? 1'b1 : 1'b0}));
        end
        tx_enable = 1;
        for (int i = 0; i < 12; i++) send_one(8'h50 + 8'(i));

        // Flow control: cts_n gates only the start of a frame
        cts_n = 1;
        push(8'h61);
        push(8'h62);
        repeat (5) tick();
        check("cts hold", int'({start_tx, busy, level}), int'({2'b00, 5'd2}));
        cts_n = 0;
        tick(); tick();
        check("cts send", int'({start_tx, tx_data}), int'({1'b1, 8'h61}));
        cts_n = 1; tick();
        check("cts mid1", int'({start_tx, tx_data}), int'({1'b1, 8'h61}));
        cts_n = 0; tick();
        check("cts mid2", int'({start_tx, tx_data}), int'({1'b1, 8'h61}));
        cts_n = 1;
        tx_done = 1; tick(); tx_done = 0;
        check("cts gap", int'({start_tx, busy, tx_data}), int'({2'b01, 8'h61}));
        repeat (4) tick();
        check("cts blocked", int'({start_tx, busy, level}), int'({2'b00, 5'd1}));
        flush = 1; tick(); flush = 0;

        // Asynchronous reset mid-SEND
        cts_n = 0;
        push(8'h77);
        push(8'h78);
        tick();
        check("pre-reset", int'({start_tx, tx_data, level}), int'({1'b1, 8'h77, 5'd1}));
        #1 reset = 1;
        #1;
        check("async rst", int'({start_tx, busy, tx_data, level}), 0);
        #2 reset = 0;
        tick();
        check("post rst", int'({busy, empty, start_tx}), 'b010);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
